// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_ctrl
// Description : PLL initialisation / dynamic-reconfiguration controller.
//               Holds the PLL in reset, programs N_CH divider registers over
//               the MD port, reads them back for verification, releases the
//               PLL and qualifies lock with a stability window, a timeout and
//               a bounded retry scheme. Re-programming on request.
//               Optional feature macro: PLL_RELOCK_EN (lock loss in LOCKED
//               re-enters RELEASE instead of FAIL).
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl #(
    parameter int         CLK_PERIOD   = 20,
    parameter int         N_CH         = 2,
    parameter logic [7:0] BASE_ADDR    = 8'h10,
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_STABLE  = 64,
    parameter int         LOCK_TIMEOUT = 65535,
    parameter int         MAX_RETRY    = 3
) (
    input  logic              mdclk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [8*N_CH-1:0] ch_div,
    input  logic              pll_lock,
    input  logic [7:0]        md_rdata,
    output logic              pll_reset,
    output logic [1:0]        md_opc,
    output logic              md_ainc,
    output logic [7:0]        md_wdata,
    output logic              lock,
    output logic              busy,
    output logic              err
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------------
    if (CLK_PERIOD <= 0) begin : g_chk_clk_period
        $error("pll_reconfig_ctrl: CLK_PERIOD must be positive");
    end
    if (N_CH < 1 || N_CH > 4) begin : g_chk_n_ch
        $error("pll_reconfig_ctrl: N_CH must be in 1..4");
    end
    if (RST_CYCLES < 2) begin : g_chk_rst_cycles
        $error("pll_reconfig_ctrl: RST_CYCLES must be >= 2");
    end
    if (LOCK_TIMEOUT < LOCK_STABLE || LOCK_STABLE < 1) begin : g_chk_lock
        $error("pll_reconfig_ctrl: need 1 <= LOCK_STABLE <= LOCK_TIMEOUT");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int CNT_MAX = (RST_CYCLES > N_CH + 1) ? RST_CYCLES : N_CH + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
    localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);

    localparam logic [1:0] OPC_NOP  = 2'b00;
    localparam logic [1:0] OPC_WR   = 2'b01;
    localparam logic [1:0] OPC_RD   = 2'b10;
    localparam logic [1:0] OPC_ADDR = 2'b11;

    localparam logic [3:0] S_RST_HOLD  = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_WR        = 4'd2;
    localparam logic [3:0] S_RADDR     = 4'd3;
    localparam logic [3:0] S_RD        = 4'd4;
    localparam logic [3:0] S_RELEASE   = 4'd5;
    localparam logic [3:0] S_WAIT_LOCK = 4'd6;
    localparam logic [3:0] S_LOCKED    = 4'd7;
    localparam logic [3:0] S_FAIL      = 4'd8;

    // ------------------------------------------------------------------------
    // State and datapath flops
    // ------------------------------------------------------------------------
    logic [3:0]        state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [STAB_W-1:0] stab_q,      stab_d;
    logic [TMO_W-1:0]  tmo_q,       tmo_d;
    logic [RTY_W-1:0]  retry_q,     retry_d;
    logic              err_q,       err_d;
    logic              mism_q,      mism_d;
    logic [8*N_CH-1:0] shadow_q,    shadow_d;
    logic              pll_reset_q, pll_reset_d;
    logic [1:0]        md_opc_q,    md_opc_d;
    logic              md_ainc_q,   md_ainc_d;
    logic [7:0]        md_wdata_q,  md_wdata_d;
    logic              busy_q,      busy_d;
    logic              lock_q,      lock_d;

    logic              bump;
    logic [7:0]        rd_exp;

    // State register plus registered outputs; async reset aborts any MD access
    always_ff @(posedge mdclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RST_HOLD;
            cnt_q       <= '0;
            stab_q      <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
            mism_q      <= 1'b0;
            shadow_q    <= '0;
            pll_reset_q <= 1'b1;
            md_opc_q    <= OPC_NOP;
            md_ainc_q   <= 1'b0;
            md_wdata_q  <= '0;
            busy_q      <= 1'b1;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            err_q       <= err_d;
            mism_q      <= mism_d;
            shadow_q    <= shadow_d;
            pll_reset_q <= pll_reset_d;
            md_opc_q    <= md_opc_d;
            md_ainc_q   <= md_ainc_d;
            md_wdata_q  <= md_wdata_d;
            busy_q      <= busy_d;
            lock_q      <= lock_d;
        end
    end

    // Next-state logic: sequencing, readback verification, lock qualification
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stab_d   = stab_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        err_d    = err_q;
        mism_d   = mism_q;
        shadow_d = shadow_q;
        bump     = 1'b0;

        // Read data arriving in RD cycle k belongs to channel k-1
        rd_exp = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(cnt_q) == i + 1) begin
                rd_exp = shadow_q[8*i +: 8];
            end
        end

        case (state_q)
            S_RST_HOLD: begin
                if (cnt_q == '0) begin
                    shadow_d = ch_div;
                end
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADDR: begin
                state_d = S_WR;
                cnt_d   = '0;
            end
            S_WR: begin
                if (cnt_q == CNT_W'(N_CH - 1)) begin
                    state_d = S_RADDR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RADDR: begin
                state_d = S_RD;
                cnt_d   = '0;
                mism_d  = 1'b0;
            end
            S_RD: begin
                if (cnt_q != '0 && md_rdata != rd_exp) begin
                    mism_d = 1'b1;
                end
                if (cnt_q == CNT_W'(N_CH)) begin
                    if (mism_d) begin
                        bump = 1'b1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_WAIT_LOCK;
                stab_d  = '0;
                tmo_d   = '0;
            end
            S_WAIT_LOCK: begin
                // Glitches restart the stability window, never the timeout
                if (!pll_lock) begin
                    stab_d = '0;
                end else if (stab_q != STAB_W'(LOCK_STABLE)) begin
                    stab_d = stab_q + STAB_W'(1);
                end
                if (tmo_q != TMO_W'(LOCK_TIMEOUT)) begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
                if (stab_d == STAB_W'(LOCK_STABLE)) begin
                    state_d = S_LOCKED;
                    retry_d = '0;
                end else if (tmo_d == TMO_W'(LOCK_TIMEOUT)) begin
                    bump = 1'b1;
                end
            end
            S_LOCKED: begin
                if (req) begin
                    state_d = S_RST_HOLD;
                    cnt_d   = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                end else if (!pll_lock) begin
`ifdef PLL_RELOCK_EN
                    state_d = S_RELEASE;
                    retry_d = '0;
`else
                    state_d = S_FAIL;
                    err_d   = 1'b1;
`endif
                end
            end
            S_FAIL: begin
                if (req) begin
                    state_d = S_RST_HOLD;
                    cnt_d   = '0;
                    retry_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_RST_HOLD;
                cnt_d   = '0;
            end
        endcase

        // Failed pass: rerun the full sequence unless retries are exhausted
        if (bump) begin
            if (retry_q >= RTY_W'(MAX_RETRY)) begin
                state_d = S_FAIL;
                err_d   = 1'b1;
            end else begin
                state_d = S_RST_HOLD;
                cnt_d   = '0;
                retry_d = retry_q + RTY_W'(1);
            end
        end
    end

    // Output decode from the next state so registered outputs align with it
    always_comb begin
        pll_reset_d = 1'b1;
        md_opc_d    = OPC_NOP;
        md_ainc_d   = 1'b0;
        md_wdata_d  = '0;
        busy_d      = 1'b1;
        lock_d      = 1'b0;
        case (state_d)
            S_ADDR, S_RADDR: begin
                md_opc_d   = OPC_ADDR;
                md_wdata_d = BASE_ADDR;
            end
            S_WR: begin
                md_opc_d  = OPC_WR;
                md_ainc_d = 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    if (int'(cnt_d) == i) begin
                        md_wdata_d = shadow_d[8*i +: 8];
                    end
                end
            end
            S_RD: begin
                if (cnt_d < CNT_W'(N_CH)) begin
                    md_opc_d  = OPC_RD;
                    md_ainc_d = 1'b1;
                end
            end
            S_RELEASE, S_WAIT_LOCK: begin
                pll_reset_d = 1'b0;
            end
            S_LOCKED: begin
                pll_reset_d = 1'b0;
                busy_d      = 1'b0;
                lock_d      = 1'b1;
            end
            S_FAIL: begin
                busy_d = 1'b0;
            end
            default: begin
                pll_reset_d = 1'b1;
            end
        endcase
    end

    // Port drive; lock drops in the same cycle the raw lock falls
    assign pll_reset = pll_reset_q;
    assign md_opc    = md_opc_q;
    assign md_ainc   = md_ainc_q;
    assign md_wdata  = md_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign lock      = lock_q & pll_lock;

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pll_reconfig_ctrl
// Description : Scoreboard bench for pll_reconfig_ctrl with an MD register
//               model, a PLL lock model and randomized divider values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

    localparam int         N_CH         = 2;
    localparam logic [7:0] BASE         = 8'h10;
    localparam int         RST_CYCLES   = 16;
    localparam int         LOCK_STABLE  = 64;
    localparam int         LOCK_TIMEOUT = 200;
    localparam int         MAX_RETRY    = 3;
    // Cycles from sequence start to the first WAIT_LOCK cycle
    localparam int         SEQ_MD       = RST_CYCLES + 2 * N_CH + 4;
    // Length of a pass that ends on a readback mismatch
    localparam int         SEQ_RD_FAIL  = RST_CYCLES + 2 * N_CH + 3;

    logic              mdclk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req   = 1'b0;
    logic [8*N_CH-1:0] ch_div;
    logic              pll_lock;
    logic [7:0]        md_rdata;
    logic              pll_reset;
    logic [1:0]        md_opc;
    logic              md_ainc;
    logic [7:0]        md_wdata;
    logic              lock;
    logic              busy;
    logic              err;

    pll_reconfig_ctrl #(
        .CLK_PERIOD  (20),
        .N_CH        (N_CH),
        .BASE_ADDR   (BASE),
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .mdclk    (mdclk),
        .rst_n    (rst_n),
        .req      (req),
        .ch_div   (ch_div),
        .pll_lock (pll_lock),
        .md_rdata (md_rdata),
        .pll_reset(pll_reset),
        .md_opc   (md_opc),
        .md_ainc  (md_ainc),
        .md_wdata (md_wdata),
        .lock     (lock),
        .busy     (busy),
        .err      (err)
    );

    always #10 mdclk = ~mdclk;

    int cyc = 0;
    always @(posedge mdclk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [10:0] md_q[$];   // expected {opc, ainc, wdata}
    int          lock_q[$]; // expected cycle of each lock rise

    logic        lock_en    = 1'b1;
    int          glitch_cyc = -1;
    bit          corrupt    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_seq(input logic [8*N_CH-1:0] d);
        md_q.push_back({2'b11, 1'b0, BASE});
        for (int i = 0; i < N_CH; i++) md_q.push_back({2'b01, 1'b1, d[8*i +: 8]});
        md_q.push_back({2'b11, 1'b0, BASE});
        for (int i = 0; i < N_CH; i++) md_q.push_back({2'b10, 1'b1, 8'h00});
    endtask

    function automatic logic [8*N_CH-1:0] rand_div();
        logic [31:0] r;
        r = $urandom;
        return r[8*N_CH-1:0];
    endfunction

    // ---------------- MD register model (one-cycle read latency) -----------
    logic [7:0] mem [256];
    logic [7:0] md_addr;
    logic [7:0] md_nxt;
    initial begin
        md_rdata = 8'h00;
        md_addr  = 8'h00;
        forever begin
            @(negedge mdclk);
            md_nxt = 8'h00;
            case (md_opc)
                2'b11: md_addr = md_wdata;
                2'b01: begin
                    mem[md_addr] = md_wdata;
                    if (md_ainc) md_addr = md_addr + 8'd1;
                end
                2'b10: begin
                    md_nxt = mem[md_addr];
                    if (corrupt && md_addr == BASE + 8'd1) begin
                        md_nxt  = ~md_nxt;
                        corrupt = 1'b0;
                    end
                    if (md_ainc) md_addr = md_addr + 8'd1;
                end
                default: ;
            endcase
            @(posedge mdclk);
            #1 md_rdata = md_nxt;
        end
    end

    // ---------------- PLL model: locks whenever its reset is released -----
    initial begin
        pll_lock = 1'b0;
        forever begin
            @(negedge mdclk);
            #2 pll_lock = lock_en && !pll_reset && (cyc != glitch_cyc);
        end
    end

    // ---------------- MD transaction monitor -----------------------------
    initial begin
        logic [10:0] exp;
        forever begin
            @(negedge mdclk);
            if (md_opc != 2'b00) begin
                if (md_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL md_unexpected: actual opc=%b ainc=%b wdata=%h required no MD operation (cycle %0d)",
                             md_opc, md_ainc, md_wdata, cyc);
                end else begin
                    exp = md_q.pop_front();
                    check("md_op", {21'd0, md_opc, md_ainc, md_wdata}, {21'd0, exp});
                end
            end else begin
                check("md_idle", {23'd0, md_ainc, md_wdata}, 32'd0);
            end
        end
    end

    // ---------------- lock rise monitor ----------------------------------
    initial begin
        logic lock_prev;
        lock_prev = 1'b0;
        forever begin
            @(negedge mdclk);
            if (lock === 1'b1 && lock_prev !== 1'b1) begin
                if (lock_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL lock_unexpected: actual lock rise at cycle %0d required none", cyc);
                end else begin
                    check("lock_cycle", cyc, lock_q.pop_front());
                    check("busy_at_lock", busy, 0);
                end
            end
            lock_prev = lock;
        end
    end

    // ---------------- helpers --------------------------------------------
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge mdclk);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && (md_q.size() != 0 || lock_q.size() != 0); i++)
            @(negedge mdclk);
        check("queues_drained", md_q.size() + lock_q.size(), 0);
    endtask

    task automatic start_req(input logic [8*N_CH-1:0] d, output int s);
        ch_div = d;
        push_seq(d);
        req = 1'b1;
        @(negedge mdclk);
        req = 1'b0;
        s = cyc;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_md_opc"},    md_opc,    0);
        check({tag, "_md_ainc"},   md_ainc,   0);
        check({tag, "_md_wdata"},  md_wdata,  0);
        check({tag, "_lock"},      lock,      0);
        check({tag, "_busy"},      busy,      1);
        check({tag, "_err"},       err,       0);
    endtask

    task automatic check_locked(input string tag);
        check({tag, "_lock"},      lock,      1);
        check({tag, "_busy"},      busy,      0);
        check({tag, "_err"},       err,       0);
        check({tag, "_pll_reset"}, pll_reset, 0);
    endtask

    // ---------------- watchdog -------------------------------------------
    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: actual simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus -------------------------------------------
    initial begin : main
        int s;
        int f;
        int g;
        int qr;
        int L;
        int k;
        logic [8*N_CH-1:0] d;

        ch_div = 16'h0A05;
        repeat (3) @(negedge mdclk);
        check_reset("reset");

        // Clean bring-up from reset release
        push_seq(ch_div);
        lock_q.push_back(cyc + SEQ_MD + LOCK_STABLE);
        rst_n = 1'b1;
        wait_done(3000);
        check_locked("bringup");

        // Re-program on req; req and a ch_div change during WR are ignored
        d = rand_div();
        start_req(d, s);
        lock_q.push_back(s + SEQ_MD + LOCK_STABLE);
        wait_until(s + RST_CYCLES + 1);
        req    = 1'b1;
        ch_div = ~d;
        @(negedge mdclk);
        req = 1'b0;
        wait_done(3000);
        check_locked("req_in_wr");

        // Readback mismatch on channel 1: one retry then success
        d       = rand_div();
        corrupt = 1'b1;
        start_req(d, s);
        push_seq(d);
        lock_q.push_back(s + SEQ_RD_FAIL + SEQ_MD + LOCK_STABLE);
        wait_done(3000);
        check_locked("mismatch");

        // Lock glitch at stability count 40
        d = rand_div();
        start_req(d, s);
        g = s + SEQ_MD + 40;
        glitch_cyc = g;
        lock_q.push_back(g + 1 + LOCK_STABLE);
        wait_done(3000);
        check_locked("glitch40");

        // Randomized rounds: random glitch position, ignored busy-time req
        for (int r = 0; r < 3; r++) begin
            d = rand_div();
            start_req(d, s);
            g = s + SEQ_MD + int'($urandom_range(LOCK_STABLE - 1, 0));
            glitch_cyc = g;
            lock_q.push_back(g + 1 + LOCK_STABLE);
            qr = s + int'($urandom_range(g + LOCK_STABLE - s, 0));
            wait_until(qr);
            req = 1'b1;
            @(negedge mdclk);
            req = 1'b0;
            wait_done(3000);
            check_locked("rand_round");
        end

        // Lock loss in LOCKED
        L = cyc;
        glitch_cyc = L;
        #3;
        check("lock_drop_same_cycle", lock, 0);
`ifdef PLL_RELOCK_EN
        lock_q.push_back(L + 2 + LOCK_STABLE);
        wait_done(3000);
        check_locked("relock");
`else
        @(negedge mdclk);
        check("lockloss_err", err, 1);
        check("lockloss_busy", busy, 0);
        check("lockloss_pll_reset", pll_reset, 1);
        repeat (5) @(negedge mdclk);
        check("fail_hold_err", err, 1);
        check("fail_hold_lock", lock, 0);
`endif

        // Lock timeout: MAX_RETRY+1 full passes then FAIL
        lock_en = 1'b0;
        d = rand_div();
        start_req(d, s);
        check("req_clears_err", err, 0);
        for (int i = 0; i < MAX_RETRY; i++) push_seq(d);
        f = s + (MAX_RETRY + 1) * (SEQ_MD + LOCK_TIMEOUT);
        wait_until(f - 1);
        check("timeout_err_before", err, 0);
        check("timeout_busy_before", busy, 1);
        @(negedge mdclk);
        check("timeout_err", err, 1);
        check("timeout_pll_reset", pll_reset, 1);
        check("timeout_busy", busy, 0);
        check("timeout_lock", lock, 0);
        check("timeout_md_count", md_q.size(), 0);

        // Recovery from FAIL via req
        lock_en = 1'b1;
        d = rand_div();
        start_req(d, s);
        check("recover_err_cleared", err, 0);
        lock_q.push_back(s + SEQ_MD + LOCK_STABLE);
        wait_done(3000);
        check_locked("recover");

        // Async reset during RD, then a full rerun
        d = rand_div();
        start_req(d, s);
        k = s + RST_CYCLES + N_CH + 2;
        wait_until(k - 1);
        @(posedge mdclk);
        #3 rst_n = 1'b0;
        #1 check_reset("rst_mid_rd");
        md_q.delete();
        @(negedge mdclk);
        push_seq(ch_div);
        lock_q.push_back(cyc + SEQ_MD + LOCK_STABLE);
        rst_n = 1'b1;
        wait_done(3000);
        check_locked("after_reset");

        repeat (3) @(negedge mdclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_reconfig_ctrl.md
# pll_reconfig_ctrl

Parametrised PLL initialisation and dynamic-reconfiguration controller. It sequences PLL reset and programs N_CH output-divider registers over the PLL's MD port (opcode / auto-increment / write data / read data). It reads the registers back to verify them, then qualifies lock with a stability window and a timeout-and-retry scheme. It replaces the fixed single-output init sequencer next to each `Gowin_PLL_MOD` instance, and it supports runtime re-programming on request.

## Interface
- `CLK_PERIOD`, 20: mdclk period in ns; documentation only, not used in logic.
- `N_CH`, 2: number of divider registers programmed, 1..4.
- `BASE_ADDR`, 8'h10: MD address of the first divider register.
- `RST_CYCLES`, 16: mdclk cycles `pll_reset` is held high, ≥2.
- `LOCK_STABLE`, 64: consecutive cycles `pll_lock` must be high before `lock` asserts.
- `LOCK_TIMEOUT`, 65535: cycles allowed in WAIT_LOCK, ≥ LOCK_STABLE.
- `MAX_RETRY`, 3: full-sequence retries before FAIL.

Ports:
- `mdclk` in 1: controller clock; also drives the PLL MD port.
- `rst_n` in 1: asynchronous active-low reset.
- `req` in 1: one-cycle pulse requesting re-programming.
- `ch_div` in 8*N_CH: divider values; channel i occupies bits [8i+7:8i].
- `pll_lock` in 1: raw PLL lock, already synchronous to mdclk.
- `md_rdata` in 8: MD read data, valid one cycle after a read opcode.
- `pll_reset` out 1: PLL reset, active-high.
- `md_opc` out 2: 00 nop, 01 write, 10 read, 11 load address (address on `md_wdata`).
- `md_ainc` out 1: post-increment the MD address after this write/read.
- `md_wdata` out 8: MD write data or address.
- `lock` out 1: qualified lock.
- `busy` out 1: sequence in progress.
- `err` out 1: sticky failure flag.

## Operation
- FSM states: RST_HOLD, ADDR, WR, RADDR, RD, RELEASE, WAIT_LOCK, LOCKED, FAIL.
- Reset entry: async reset forces RST_HOLD, retry=0, err=0. The sequence starts automatically on reset release.
- `ch_div` is captured into a shadow register on the first RST_HOLD cycle. Later changes are ignored until the next sequence.
- RST_HOLD: `pll_reset`=1 for RST_CYCLES, then go to ADDR.
- ADDR: one cycle, opc=11, wdata=BASE_ADDR. Then WR.
- WR: N_CH cycles, opc=01, ainc=1, wdata=shadow[i] for i=0..N_CH-1. Then RADDR.
- RADDR: one cycle, opc=11, wdata=BASE_ADDR. Then RD.
- RD: issue N_CH reads (opc=10, ainc=1) on consecutive cycles. `md_rdata` is compared with shadow[i] on the following cycle, so the state lasts N_CH+1 cycles.
  - All channels match: go to RELEASE.
  - Any mismatch: retry++ and go to RST_HOLD.
- `pll_reset` stays 1 from RST_HOLD through RD.
- RELEASE: one cycle, `pll_reset`=0. Then WAIT_LOCK with both counters cleared.
- WAIT_LOCK:
  - The stability counter increments while `pll_lock`=1 and clears when it is 0.
  - Reaching LOCK_STABLE: go to LOCKED, `lock`=1, retry=0.
  - Timeout counter reaching LOCK_TIMEOUT: retry++ and go to RST_HOLD.
- Retry exhaustion: when an increment would make retry exceed MAX_RETRY, go to FAIL instead. FAIL: err=1, `pll_reset`=1, idle.
- LOCKED: on a `pll_lock` falling edge, `lock` drops in the same cycle (combinational AND with raw lock). Further behaviour depends on the Configuration macro.
- `req`:
  - In LOCKED or FAIL: clears err and retry, then goes to RST_HOLD.
  - In any other state: ignored, not queued.
- Outputs: `busy`=1 in every state except LOCKED and FAIL. `md_opc`=00, `md_ainc`=0 and `md_wdata`=0 whenever no MD operation is issued.

## Timing
- Reset values: `pll_reset`=1, `md_opc`=00, `md_ainc`=0, `md_wdata`=0, `lock`=0, `busy`=1, `err`=0.
- All outputs except `lock` are registered.
- Latency of a clean sequence from reset release or `req` to the first `lock`=1: RST_CYCLES + 2N_CH + 4 + LOCK_STABLE cycles, with `pll_lock` high from RELEASE.
- A `pll_lock` glitch during WAIT_LOCK restarts the stability count but not the timeout.
- Counters saturate and never wrap.
- Async reset mid-sequence aborts any MD operation immediately. There is no partial-write recovery; the full sequence reruns.

## Configuration
- `PLL_RELOCK_EN` defined: lock loss in LOCKED sets retry=0 and re-enters RELEASE. The PLL is not reset or reprogrammed; WAIT_LOCK rules apply, including timeout and retries through RST_HOLD.
- `PLL_RELOCK_EN` undefined: lock loss in LOCKED goes to FAIL, err=1, and the controller stays there until `req` or reset.

## Test plan
- Clean bring-up: N_CH=2, ch_div=16'h0A05, model returns written data, lock high from RELEASE.
  - MD writes: addr 10 → 05, 0A; reads: 05, 0A.
  - `lock`=1 exactly RST_CYCLES+8+LOCK_STABLE cycles after reset release; `busy`=0.
- Readback mismatch: model corrupts the first read of channel 1 → retry, second pass succeeds, `lock`=1, `err`=0.
- Lock timeout: `pll_lock` held 0 → MAX_RETRY+1 full sequences, then FAIL with `err`=1, `pll_reset`=1, `busy`=0. A subsequent `req` clears err and restarts.
- Lock glitch: `pll_lock` drops for 1 cycle at stability count 40 of 64 → `lock` asserts 64 cycles after the glitch.
- Lock loss in LOCKED: `lock` falls the same cycle.
  - With `PLL_RELOCK_EN`: no MD traffic; re-lock after LOCK_STABLE.
  - Without it: `err`=1 and the FSM holds in FAIL.
- `req` during WR: ignored, sequence unchanged. `rst_n` low mid-RD: outputs return to reset values asynchronously.
